// File: rtl/timestamper_start_ctrl.sv
// timestamper_start_ctrl
//   Capture controller fed by the startBuffer software register. It decodes
//   start/cont/use_sync from the register word, optionally waits for a sync
//   pulse, writes a window of timestamp words into a capture BRAM and exposes
//   progress through a status word for PPC readback.
//
// Ports
//   user_clk    : single clock for all logic
//   user_rst_n  : synchronous active-low reset
//   start_reg   : startBuffer value; [0] start, [1] cont (wrap), [2] use_sync
//   sync_in     : single-cycle sync/PPS pulse, honoured only while ARMED
//   din         : timestamp word
//   din_valid   : din qualifier
//   bram_we     : BRAM write enable (registered)
//   bram_addr   : BRAM write address (registered)
//   bram_din    : BRAM write data (registered)
//   busy        : high in ARMED or CAPTURE
//   done        : high in DONE
//   wr_count    : words written since the last arm, saturating at 2^ADDR_W
//   status      : {state[1:0], overflow, zeros, wr_count}
module timestamper_start_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       start_reg,
  input  logic              sync_in,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'((1 << ADDR_W) - 1);

  state_t            r_state;
  logic              r_start_q;
  logic              r_cont;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_wr_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  logic w_start;
  logic w_arm;
  logic w_abort;
  logic w_full;
  logic w_window;
  logic w_accept;
  logic w_last;
  logic w_unused_bits;

  assign w_start  = start_reg[0];
  assign w_arm    = w_start & ~r_start_q;
  assign w_abort  = ~w_start;
  // wr_count saturates at 2^ADDR_W, so its MSB alone means "full".
  assign w_full   = r_wr_count[ADDR_W];
  // A sync pulse while ARMED opens the window in the same cycle, so a word
  // arriving alongside sync becomes word 0.
  assign w_window = (r_state == CAPTURE) | ((r_state == ARMED) & sync_in);
  assign w_accept = w_window & din_valid & ~w_abort & ~(w_full & ~r_cont);
  assign w_last   = w_accept & ~r_cont & (r_wr_count == LAST_COUNT);

  assign w_unused_bits = ^start_reg[31:3];

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      r_state    <= IDLE;
      r_start_q  <= 1'b0;
      r_cont     <= 1'b0;
      r_overflow <= 1'b0;
      r_ptr      <= '0;
      r_wr_count <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_start_q <= w_start;
      r_we      <= w_accept;

      if (w_accept) begin
        r_addr <= r_ptr;
        r_din  <= din;
        r_ptr  <= r_ptr + ADDR_W'(1);
        // Overflow marks the first word that overwrites an earlier one.
        if (!w_full) r_wr_count <= r_wr_count + (ADDR_W+1)'(1);
        else         r_overflow <= 1'b1;
      end

      // No accept can happen in IDLE, so the arm clears below never
      // collide with the counter updates above.
      case (r_state)
        IDLE: begin
          if (w_arm) begin
            r_cont     <= start_reg[1];
            r_ptr      <= '0;
            r_wr_count <= '0;
            r_overflow <= 1'b0;
            r_state    <= start_reg[2] ? ARMED : CAPTURE;
          end
        end
        ARMED: begin
          if (w_abort)      r_state <= IDLE;
          else if (sync_in) r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (w_abort)     r_state <= IDLE;
          else if (w_last) r_state <= DONE;
        end
        DONE: begin
          if (w_abort) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bram_we   = r_we;
  assign bram_addr = r_addr;
  assign bram_din  = r_din;
  assign busy      = (r_state == ARMED) | (r_state == CAPTURE);
  assign done      = (r_state == DONE);
  assign wr_count  = r_wr_count;

  always_comb begin
    status             = '0;
    status[31:30]      = r_state;
    status[29]         = r_overflow;
    status[ADDR_W:0]   = r_wr_count;
  end

endmodule

// File: tb/tb_timestamper_start_ctrl.sv
module tb_timestamper_start_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          user_clk = 1'b0;
  logic          user_rst_n;
  logic [31:0]   start_reg;
  logic          sync_in;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic [31:0]   status;

  always #5 user_clk = ~user_clk;

  timestamper_start_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .start_reg (start_reg),
    .sync_in   (sync_in),
    .din       (din),
    .din_valid (din_valid),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .status    (status)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];

  typedef struct {
    logic [31:0]   s;
    logic          sy;
    logic          v;
    logic [DW-1:0] d;
    bit            acc;
    logic [AW-1:0] a;
    logic          ewe;
    logic [1:0]    est;
    logic          ebusy;
    logic          edone;
    logic [AW:0]   ewc;
    logic          eovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic [1:0] st, input logic ovf, input logic [AW:0] wc);
    return {st, ovf, 24'h0, wc};
  endfunction

  // Drive one cycle of inputs at a negedge; return at the following negedge,
  // where outputs reflect the intervening posedge.
  task automatic cyc(input logic [31:0] s, input logic sy, input logic v,
                     input logic [DW-1:0] d, input bit acc, input logic [AW-1:0] a);
    start_reg = s;
    sync_in   = sy;
    din_valid = v;
    din       = d;
    if (acc) sb_q.push_back('{addr: a, data: d});
    @(negedge user_clk);
  endtask

  // Write monitor: every BRAM write must match the oldest expected write.
  always @(posedge user_clk) begin
    #2;
    if (bram_we === 1'b1) begin
      wr_t e;
      n_writes++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with none expected", bram_addr, bram_din);
      end else begin
        e = sb_q.pop_front();
        check("write_addr", 32'(bram_addr), 32'(e.addr));
        check("write_data", bram_din, e.data);
      end
    end
  end

  initial begin
    int base;
    int k;

    user_rst_n = 1'b0;
    start_reg  = '0;
    sync_in    = 1'b0;
    din        = '0;
    din_valid  = 1'b0;

    // Reset state
    @(negedge user_clk);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_we", 32'(bram_we), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_din", bram_din, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_status", status, 0);
    user_rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);

    // 1. Single-shot capture of 20 offered words
    base = n_writes;
    cyc(32'h1, 0, 0, 0, 0, 0);
    check("t1_arm_busy", 32'(busy), 1);
    check("t1_arm_status", status, 32'h8000_0000);
    for (int i = 0; i < 20; i++) begin
      cyc(32'h1, 0, 1, DW'(i), i < 16, AW'(i));
      if (i == 14) check("t1_done_early", 32'(done), 0);
      if (i == 15) begin
        check("t1_last_we", 32'(bram_we), 1);
        check("t1_last_done", 32'(done), 1);
        check("t1_last_status", status, 32'hC000_0010);
      end
      if (i == 16) check("t1_no_write_after_full", 32'(bram_we), 0);
    end
    check("t1_write_total", 32'(n_writes - base), 16);
    check("t1_done_hold", 32'(done), 1);
    cyc(32'h0, 0, 0, 0, 0, 0);
    check("t1_idle_status", status, 32'h0000_0010);
    check("t1_idle_busy", 32'(busy), 0);

    // 2. Sync-gated arm, table driven
    vecs[0] = '{32'h5, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 2'd1, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[1] = '{32'h5, 1'b0, 1'b1, 32'h11, 1'b0, 4'd0, 1'b0, 2'd1, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[2] = '{32'h5, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 2'd1, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[3] = '{32'h5, 1'b0, 1'b1, 32'h22, 1'b0, 4'd0, 1'b0, 2'd1, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[4] = '{32'h5, 1'b1, 1'b1, 32'hAA, 1'b1, 4'd0, 1'b1, 2'd2, 1'b1, 1'b0, 5'd1, 1'b0};
    vecs[5] = '{32'h5, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 2'd2, 1'b1, 1'b0, 5'd1, 1'b0};
    vecs[6] = '{32'h5, 1'b0, 1'b1, 32'hBB, 1'b1, 4'd1, 1'b1, 2'd2, 1'b1, 1'b0, 5'd2, 1'b0};
    vecs[7] = '{32'h0, 1'b0, 1'b1, 32'hCC, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd2, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].s, vecs[i].sy, vecs[i].v, vecs[i].d, vecs[i].acc, vecs[i].a);
      check($sformatf("t2_we[%0d]", i), 32'(bram_we), 32'(vecs[i].ewe));
      check($sformatf("t2_busy[%0d]", i), 32'(busy), 32'(vecs[i].ebusy));
      check($sformatf("t2_done[%0d]", i), 32'(done), 32'(vecs[i].edone));
      check($sformatf("t2_status[%0d]", i), status,
            exp_status(vecs[i].est, vecs[i].eovf, vecs[i].ewc));
    end

    // 3. Continuous wrap mode
    cyc(32'h3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      cyc(32'h3, 0, 1, DW'(i), 1, AW'(i % 16));
      if (i == 15) check("t3_full_no_ovf", status, 32'h8000_0010);
      if (i == 16) check("t3_first_ovf", status, 32'hA000_0010);
    end
    check("t3_final_status", status, 32'hA000_0010);
    check("t3_still_busy", 32'(busy), 1);
    cyc(32'h0, 0, 0, 0, 0, 0);
    check("t3_idle_status", status, 32'h2000_0010);

    // 4. Abort while data keeps flowing
    base = n_writes;
    cyc(32'h1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(32'h1, 0, 1, DW'(32'h100 + i), 1, AW'(i));
    cyc(32'h0, 0, 1, 32'h1FE, 0, 0);
    check("t4_abort_we", 32'(bram_we), 0);
    check("t4_abort_status", status, 32'h0000_0005);
    cyc(32'h0, 0, 1, 32'h1FF, 0, 0);
    check("t4_write_total", 32'(n_writes - base), 5);
    cyc(32'h1, 0, 0, 0, 0, 0);
    check("t4_rearm_status", status, 32'h8000_0000);
    cyc(32'h0, 0, 0, 0, 0, 0);

    // 5. Gapped input, then fill and hold start high in DONE
    cyc(32'h1, 0, 0, 0, 0, 0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      logic v;
      v = (i % 2 == 0);
      cyc(32'h1, 0, v, DW'(32'h500 + i), v, AW'(k));
      if (v) k++;
      check($sformatf("t5_gap_we[%0d]", i), 32'(bram_we), 32'(v));
    end
    check("t5_gap_count", 32'(wr_count), 5);
    for (int i = 0; i < 11; i++) cyc(32'h1, 0, 1, DW'(32'h600 + i), 1, AW'(5 + i));
    check("t5_done", 32'(done), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(32'h1, 0, 1, DW'(32'h6F0 + i), 0, 0);
      check($sformatf("t5_hold_status[%0d]", i), status, 32'hC000_0010);
      check($sformatf("t5_hold_we[%0d]", i), 32'(bram_we), 0);
    end
    cyc(32'h0, 0, 0, 0, 0, 0);
    check("t5_idle_status", status, 32'h0000_0010);

    // 6. Reset in the middle of a capture
    cyc(32'h1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(32'h1, 0, 1, DW'(32'h700 + i), 1, AW'(i));
    user_rst_n = 1'b0;
    cyc(32'h1, 0, 1, 32'h7FF, 0, 0);
    check("t6_rst_we", 32'(bram_we), 0);
    check("t6_rst_addr", 32'(bram_addr), 0);
    check("t6_rst_din", bram_din, 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_wr_count", 32'(wr_count), 0);
    check("t6_rst_status", status, 0);
    user_rst_n = 1'b1;
    cyc(32'h1, 0, 0, 0, 0, 0);
    check("t6_rearm_after_rst", status, 32'h8000_0000);
    cyc(32'h0, 0, 0, 0, 0, 0);
    cyc(32'h0, 0, 0, 0, 0, 0);

    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
